// File: rtl/fifo_uart_tx.sv
// Pops one word per frame from a synchronous FIFO and shifts it out as an async serial frame.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for enIn with a non-empty FIFO
// FETCH  | rdEnOut high for exactly one cycle
// LOAD   | FIFO data valid; capture it and drive the start bit
// START  | start bit (low) for one bit time
// DATA   | DATA_WIDTH payload bits, LSB first
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | STOP_BITS stop bits (high)
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  enIn,
    input  logic                  isEmptyIn,
    input  logic [DATA_WIDTH-1:0] rdDataIn,
    output logic                  rdEnOut,
    output logic                  txOut,
    output logic                  busyOut
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } stateT;

    stateT                  state, stateNext;
    logic [DATA_WIDTH-1:0]  shiftReg, shiftNext;
    logic [BAUD_W-1:0]      baudCnt, baudNext;
    logic [BIT_W-1:0]       bitCnt, bitNext;
    logic                   txNext;
    logic                   rdEnNext;
    logic                   baudDone;
`ifdef UART_TX_PARITY_EN
    logic                   parityBit, parityNext;
`endif

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state     <= IDLE;
            shiftReg  <= '0;
            baudCnt   <= '0;
            bitCnt    <= '0;
            txOut     <= 1'b1;
            rdEnOut   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            state     <= stateNext;
            shiftReg  <= shiftNext;
            baudCnt   <= baudNext;
            bitCnt    <= bitNext;
            txOut     <= txNext;
            rdEnOut   <= rdEnNext;
`ifdef UART_TX_PARITY_EN
            parityBit <= parityNext;
`endif
        end
    end

    assign baudDone = (baudCnt == BAUD_LAST);
    assign busyOut  = (state != IDLE);

    always_comb begin
        stateNext  = state;
        shiftNext  = shiftReg;
        baudNext   = baudCnt;
        bitNext    = bitCnt;
        txNext     = txOut;
        rdEnNext   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parityNext = parityBit;
`endif
        case (state)
            IDLE: begin
                txNext   = 1'b1;
                baudNext = '0;
                bitNext  = '0;
                if (enIn && !isEmptyIn) begin
                    rdEnNext  = 1'b1;
                    stateNext = FETCH;
                end
            end
            FETCH: begin
                stateNext = LOAD;
            end
            LOAD: begin
                shiftNext  = rdDataIn;
`ifdef UART_TX_PARITY_EN
                parityNext = ^rdDataIn;
`endif
                txNext     = 1'b0;
                baudNext   = '0;
                bitNext    = '0;
                stateNext  = START;
            end
            START: begin
                if (baudDone) begin
                    baudNext  = '0;
                    txNext    = shiftReg[0];
                    shiftNext = shiftReg >> 1;
                    stateNext = DATA;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            DATA: begin
                if (baudDone) begin
                    baudNext = '0;
                    if (bitCnt == DATA_LAST) begin
                        bitNext   = '0;
`ifdef UART_TX_PARITY_EN
                        txNext    = parityBit;
                        stateNext = PARITY;
`else
                        txNext    = 1'b1;
                        stateNext = STOP;
`endif
                    end else begin
                        // shiftReg[0] already holds the next payload bit
                        bitNext   = bitCnt + 1'b1;
                        txNext    = shiftReg[0];
                        shiftNext = shiftReg >> 1;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baudDone) begin
                    baudNext  = '0;
                    txNext    = 1'b1;
                    stateNext = STOP;
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
`endif
            STOP: begin
                txNext = 1'b1;
                if (baudDone) begin
                    baudNext = '0;
                    if (bitCnt == STOP_LAST) begin
                        bitNext   = '0;
                        stateNext = IDLE;
                    end else begin
                        bitNext = bitCnt + 1'b1;
                    end
                end else begin
                    baudNext = baudCnt + 1'b1;
                end
            end
            default: begin
                txNext    = 1'b1;
                stateNext = IDLE;
            end
        endcase
    end

endmodule
